inlier_streamer: RTL and testbench

Downstream stage of the `Controller` ROR filter: drains the outlier-index FIFO once the controller reports `done`, marks those indices in an internal bitmap, then re-reads the point cloud from point memory and streams out only the surviving (inlier) points over a valid/ready interface. It replaces the bench-side "zero the outliers and dump" loop with synthesizable hardware that feeds the output DMA.

---
 rtl/inlier_streamer.sv | 159 +++++++++++++++
 tb/tb_inlier_streamer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inlier_streamer.sv
// inlier_streamer: drains the outlier-index FIFO into a bitmap, then re-reads
// point memory and streams only the surviving (inlier) points over valid/ready.
module inlier_streamer #(
  parameter int N          = 16,
  parameter int MAX_POINTS = 32768
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] point_cloud_size,
  input  logic         ctrl_done,
  input  logic         fifo_empty,
  output logic         read_fifo,
  input  logic [N-1:0] outlier_pos,
  output logic         mem_rd,
  output logic [N-1:0] mem_addr,
  input  logic [N-1:0] mem_x,
  input  logic [N-1:0] mem_y,
  input  logic [N-1:0] mem_z,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_x,
  output logic [N-1:0] out_y,
  output logic [N-1:0] out_z,
  output logic [N-1:0] out_index,
  output logic         out_last,
  output logic         done,
  output logic [N-1:0] outlier_count,
  output logic         err_index
);
  localparam int AW = (MAX_POINTS > 1) ? $clog2(MAX_POINTS) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, SCAN, FINISH} state_t;
  typedef struct packed {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] z;
    logic [N-1:0] idx;
  } point_t;

  state_t                state;
  logic                  ctrl_done_q, cap_pend, rd_vld;
  logic                  found, walk_on;
  logic [N-1:0]          size_q, scan_idx, rd_idx, walk_idx, last_idx;
  logic [MAX_POINTS-1:0] bitmap;
  point_t                skid0, skid1;
  logic [1:0]            occ;

  logic       pop, issue, skip, scan_end, scan_bit, walk_bit, finish;
  logic [1:0] occ_net;
  point_t     new_pt;

  assign read_fifo = (state == DRAIN) && !fifo_empty;
  assign pop       = out_valid && out_ready;
  // Occupancy the buffer will hold after this edge, counting the read already in flight.
  assign occ_net   = occ - {1'b0, pop} + {1'b0, rd_vld};
  assign scan_bit  = bitmap[scan_idx[AW-1:0]];
  assign walk_bit  = bitmap[walk_idx[AW-1:0]];
  assign scan_end  = (scan_idx == size_q) || (found && (scan_idx > last_idx));
  assign skip      = (state == SCAN) && !scan_end && scan_bit;
  assign issue     = (state == SCAN) && !scan_end && !scan_bit && (occ_net < 2'd2);
  assign finish    = (state == SCAN) && scan_end && !rd_vld && (occ_net == 2'd0);
  assign mem_rd    = issue;
  assign mem_addr  = scan_idx;
  assign new_pt    = '{x: mem_x, y: mem_y, z: mem_z, idx: rd_idx};

  // The head beat is only offered once we know whether it is the final inlier:
  // either a newer inlier exists behind it, or the backward walker has located the last one.
  assign out_valid = (occ != 2'd0) && (found || (occ == 2'd2) || rd_vld);
  assign out_last  = (occ != 2'd0) && found && (skid0.idx == last_idx);
  assign out_x     = skid0.x;
  assign out_y     = skid0.y;
  assign out_z     = skid0.z;
  assign out_index = skid0.idx;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ctrl_done_q   <= ctrl_done;
      cap_pend      <= 1'b0;
      rd_vld        <= 1'b0;
      rd_idx        <= '0;
      found         <= 1'b0;
      walk_on       <= 1'b0;
      walk_idx      <= '0;
      last_idx      <= '0;
      size_q        <= '0;
      scan_idx      <= '0;
      bitmap        <= '0;
      skid0         <= '0;
      skid1         <= '0;
      occ           <= 2'd0;
      done          <= 1'b0;
      outlier_count <= '0;
      err_index     <= 1'b0;
    end else begin
      ctrl_done_q <= ctrl_done;
      cap_pend    <= read_fifo;
      rd_vld      <= issue;
      done        <= 1'b0;
      if (issue) rd_idx <= scan_idx;

      if (cap_pend) begin
        if (outlier_pos >= size_q) err_index <= 1'b1;
        else if (!bitmap[outlier_pos[AW-1:0]]) begin
          bitmap[outlier_pos[AW-1:0]] <= 1'b1;
          outlier_count               <= outlier_count + N'(1);
        end
      end

      if (rd_vld && pop) begin
        if (occ == 2'd2) begin
          skid0 <= skid1;
          skid1 <= new_pt;
        end else skid0 <= new_pt;
      end else if (pop) begin
        skid0 <= skid1;
        occ   <= occ - 2'd1;
      end else if (rd_vld) begin
        if (occ == 2'd0) skid0 <= new_pt;
        else skid1 <= new_pt;
        occ <= occ + 2'd1;
      end

      case (state)
        IDLE: if (ctrl_done && !ctrl_done_q) begin
          state         <= DRAIN;
          bitmap        <= '0;
          outlier_count <= '0;
          err_index     <= 1'b0;
          size_q        <= point_cloud_size;
        end
        // Final capture lands on the same edge as the move to SCAN, so SCAN sees it.
        DRAIN: if (fifo_empty) begin
          state    <= SCAN;
          scan_idx <= '0;
          found    <= 1'b0;
          walk_on  <= (size_q != '0);
          walk_idx <= size_q - N'(1);
        end
        SCAN: begin
          if (skip || issue) scan_idx <= scan_idx + N'(1);
          if (walk_on && !found) begin
            if (!walk_bit) begin
              found    <= 1'b1;
              last_idx <= walk_idx;
            end else if (walk_idx == '0) walk_on <= 1'b0;
            else walk_idx <= walk_idx - N'(1);
          end
          if (finish) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inlier_streamer.sv
// Directed bench for inlier_streamer: table of frames plus hand-written
// sequences for backpressure, back-to-back frames and mid-frame reset.
module tb_inlier_streamer;
  localparam int N = 16;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] point_cloud_size = '0;
  logic         ctrl_done = 1'b0;
  logic         fifo_empty, read_fifo;
  logic [N-1:0] outlier_pos = '0;
  logic         mem_rd;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_x = '0, mem_y = '0, mem_z = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_x, out_y, out_z, out_index;
  logic         out_last, done;
  logic [N-1:0] outlier_count;
  logic         err_index;

  always #5 clock = ~clock;

  inlier_streamer dut (
    .clock(clock), .reset(reset), .point_cloud_size(point_cloud_size),
    .ctrl_done(ctrl_done), .fifo_empty(fifo_empty), .read_fifo(read_fifo),
    .outlier_pos(outlier_pos), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_x(mem_x), .mem_y(mem_y), .mem_z(mem_z), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_index(out_index), .out_last(out_last), .done(done),
    .outlier_count(outlier_count), .err_index(err_index)
  );

  function automatic logic [N-1:0] fx(input logic [N-1:0] a); return a * 16'd3 + 16'd1; endfunction
  function automatic logic [N-1:0] fy(input logic [N-1:0] a); return a + 16'd100; endfunction
  function automatic logic [N-1:0] fz(input logic [N-1:0] a); return a ^ 16'h55AA; endfunction

  // Outlier FIFO and point memory models
  logic [N-1:0] fifo_mem [64];
  int wr_ptr = 0, rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clock) begin
    if (read_fifo) begin
      outlier_pos <= fifo_mem[rd_ptr % 64];
      rd_ptr      <= rd_ptr + 1;
    end
    if (mem_rd) begin
      mem_x <= fx(mem_addr);
      mem_y <= fy(mem_addr);
      mem_z <= fz(mem_addr);
    end
  end

  // out_ready: constant 1, or the 1,0,0 repeating pattern
  bit rdy_tog = 1'b0;
  int rcnt = 0;
  always @(posedge clock) begin
    #1;
    if (rdy_tog) begin
      out_ready = (rcnt % 3 == 0);
      rcnt++;
    end else out_ready = 1'b1;
  end

  // Output monitor
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  int nb = 0, done_cnt = 0, done_cyc = 0, pop_empty = 0, data_err = 0, stall_err = 0, stall_chk = 0;
  logic [N-1:0] b_idx [256];
  logic         b_last [256];
  int           b_cyc [256];
  logic         hold_v = 1'b0;
  logic [4*N:0] hold_d = '0;
  always @(negedge clock) begin
    if (hold_v) begin
      stall_chk++;
      if (!out_valid || {out_last, out_x, out_y, out_z, out_index} != hold_d) stall_err++;
    end
    hold_v = out_valid && !out_ready && !reset;
    hold_d = {out_last, out_x, out_y, out_z, out_index};
    if (read_fifo && fifo_empty) pop_empty++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      if (nb < 256) begin
        b_idx[nb]  = out_index;
        b_last[nb] = out_last;
        b_cyc[nb]  = cyc;
      end
      if (out_x != fx(out_index) || out_y != fy(out_index) || out_z != fz(out_index)) data_err++;
      nb++;
    end
  end

  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_flags"}, {read_fifo, mem_rd, out_valid, out_last, done, err_index}, 0);
    chk({tag, "_count"}, outlier_count, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, {out_x, out_y, out_z, out_index}, 0);
  endtask

  typedef struct packed {
    logic [7:0]      size;
    logic [2:0]      nout;
    logic [3:0][7:0] outs;   // FIFO contents, outs[0] popped first
    logic            tog;
    logic [7:0]      mask;   // expected inlier indices
    logic [7:0]      cnt;
    logic            err;
  } vec_t;

  int c_rise = 0, last_b0 = 0;

  task automatic run_vec(input vec_t v, input string tag);
    int  b0, d0, pe0, de0, se0, sc0, n, j;
    bit  seen;
    @(negedge clock); #1;
    b0 = nb; d0 = done_cnt; pe0 = pop_empty; de0 = data_err; se0 = stall_err; sc0 = stall_chk;
    last_b0 = b0;
    rdy_tog = v.tog;
    for (int i = 0; i < int'(v.nout); i++) begin
      fifo_mem[wr_ptr % 64] = {8'd0, v.outs[i]};
      wr_ptr++;
    end
    point_cloud_size = {8'd0, v.size};
    ctrl_done = 1'b1;
    c_rise = cyc;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clock); #1;
      if (done_cnt != d0) seen = 1'b1;
    end
    ctrl_done = 1'b0;
    repeat (5) @(negedge clock);
    #1;
    rdy_tog = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    n = $countones(v.mask);
    chk({tag, "_beats"}, nb - b0, n);
    j = 0;
    for (int k = 0; k < 8; k++) begin
      if (v.mask[k] && j < n && b0 + j < 256) begin
        chk({tag, "_beat_idx"}, b_idx[b0 + j], k);
        chk({tag, "_beat_last"}, b_last[b0 + j], (j == n - 1));
        j++;
      end
    end
    if (n > 0 && b0 + n - 1 < 256) chk({tag, "_done_after_last"}, done_cyc - b_cyc[b0 + n - 1], 1);
    chk({tag, "_outlier_count"}, outlier_count, v.cnt);
    chk({tag, "_err_index"}, err_index, v.err);
    chk({tag, "_fifo_drained"}, rd_ptr, wr_ptr);
    chk({tag, "_pop_when_empty"}, pop_empty - pe0, 0);
    chk({tag, "_data"}, data_err - de0, 0);
    chk({tag, "_stall_stable"}, stall_err - se0, 0);
    if (v.tog) chk({tag, "_stalls_seen"}, (stall_chk - sc0) > 0, 1);
  endtask

  vec_t vt [9];
  int   off [6] = '{0, 1, 3, 4, 6, 7};
  int   b0, d0, nb_r;
  bit   got;

  initial begin
    vt[0] = '{8'd8, 3'd2, {8'd0, 8'd0, 8'd5, 8'd2}, 1'b0, 8'b1101_1011, 8'd2, 1'b0};
    vt[1] = '{8'd4, 3'd3, {8'd0, 8'd1, 8'd3, 8'd3}, 1'b0, 8'b0000_0101, 8'd2, 1'b0};
    vt[2] = '{8'd4, 3'd2, {8'd0, 8'd0, 8'd9, 8'd0}, 1'b0, 8'b0000_1110, 8'd1, 1'b1};
    vt[3] = '{8'd5, 3'd0, {8'd0, 8'd0, 8'd0, 8'd0}, 1'b1, 8'b0001_1111, 8'd0, 1'b0};
    vt[4] = '{8'd3, 3'd3, {8'd0, 8'd2, 8'd1, 8'd0}, 1'b0, 8'b0000_0000, 8'd3, 1'b0};
    vt[5] = '{8'd2, 3'd0, {8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 8'b0000_0011, 8'd0, 1'b0};
    vt[6] = '{8'd6, 3'd2, {8'd0, 8'd0, 8'd4, 8'd5}, 1'b0, 8'b0000_1111, 8'd2, 1'b0};
    vt[7] = '{8'd0, 3'd0, {8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 8'b0000_0000, 8'd0, 1'b0};
    vt[8] = '{8'd1, 3'd2, {8'd0, 8'd0, 8'd7, 8'd0}, 1'b0, 8'b0000_0000, 8'd1, 1'b1};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock); #1;
    chk_zero_outputs("reset");

    for (int i = 0; i < 9; i++) begin
      run_vec(vt[i], $sformatf("v%0d", i));
      if (i == 0 && last_b0 + 5 < 256) begin
        chk("v0_first_beat_latency", b_cyc[last_b0] - c_rise, 6);
        for (int k = 0; k < 6; k++) chk("v0_beat_cycle", b_cyc[last_b0 + k] - b_cyc[last_b0], off[k]);
        chk("v0_done_latency", done_cyc - c_rise, 14);
      end
    end

    // Reset in the middle of SCAN, with ctrl_done left high
    @(negedge clock); #1;
    b0 = nb; d0 = done_cnt;
    point_cloud_size = 16'd6;
    ctrl_done = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock); #1;
      if (nb - b0 >= 2) got = 1'b1;
    end
    chk("midrst_two_beats", got, 1);
    reset = 1'b1;
    @(negedge clock); #1;
    chk_zero_outputs("midrst");
    reset = 1'b0;
    nb_r = nb;
    repeat (10) @(negedge clock);
    #1;
    chk("midrst_no_restart_beats", nb - nb_r, 0);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_idle_flags", {read_fifo, mem_rd, out_valid}, 0);
    ctrl_done = 1'b0;
    run_vec('{8'd6, 3'd1, {8'd0, 8'd0, 8'd0, 8'd1}, 1'b0, 8'b0011_1101, 8'd1, 1'b0}, "postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
